// File: rtl/fnd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Hex glyphs 0-F (A, b, C, d, E, F), dp segment off.
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational nibble-to-segment decoder with decimal point and blanking.
// A blanked digit drives every segment off, dp included.
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        seg_o = SEG_OFF;
        if (!blank_i) begin
            seg_o    = GLYPH[value_i];
            seg_o[7] = ~dp_i;
        end
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed FND driver: slot counter, blank/show FSM, double-buffered
// digit data with leading-zero suppression, and registered pin outputs.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter  int DIGITS       = 8,
    parameter  int SCAN_DIV     = 100000,
    parameter  int BLANK_CYCLES = 1000,
    localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_lz_blank,
    input  logic                  i_load,
    output logic [DIGITS-1:0]     o_digit_sel,
    output logic [7:0]            o_seg,
    output logic [IDX_W-1:0]      o_digit_idx,
    output logic                  o_frame_done
);

    localparam int               CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SHOW_START = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    scan_state_e         state_q, state_d;
    logic                slot_end, wrap;

    logic [4*DIGITS-1:0] shadow_value_q, active_value_q;
    logic [DIGITS-1:0]   shadow_dp_q, active_dp_q;
    logic                shadow_lz_q, active_lz_q;
    logic                active_valid_q, pending_q;

    logic [DIGITS-1:0]   sel_q;
    logic [7:0]          seg_q;
    logic                frame_done_q;

    logic [DIGITS-1:0]   lead_zero;
    logic                zero_run;
    logic [7:0]          glyph;

    always_comb begin
        slot_end = (cnt_q == LAST_CNT);
        wrap     = slot_end && (idx_q == LAST_IDX);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        state_d  = (cnt_d < SHOW_START) ? ST_BLANK : ST_SHOW;
    end

    // Digit k is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_run     = zero_run && (active_value_q[4*k +: 4] == 4'h0);
            lead_zero[k] = active_lz_q && zero_run;
        end
    end

    fnd_seg_decoder u_decoder (
        .value_i (active_value_q[{idx_q, 2'b00} +: 4]),
        .dp_i    (active_dp_q[idx_q]),
        .blank_i (!active_valid_q || lead_zero[idx_q]),
        .seg_o   (glyph)
    );

    // NOTE: sequential state always uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_BLANK;
            sel_q        <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            if (state_q == ST_SHOW) begin
                sel_q <= ~(DIGITS'(1) << idx_q);
                seg_q <= glyph;
            end else begin
                sel_q <= '1;
                seg_q <= SEG_OFF;
            end
            // Look ahead one cycle so the pulse lands on the wrap cycle itself.
            frame_done_q <= (cnt_d == LAST_CNT) && (idx_d == LAST_IDX);
        end
    end

    // A load coinciding with the wrap stays in the shadow until the next wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            shadow_lz_q    <= 1'b0;
            active_value_q <= '0;
            active_dp_q    <= '0;
            active_lz_q    <= 1'b0;
            active_valid_q <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            if (wrap && pending_q) begin
                active_value_q <= shadow_value_q;
                active_dp_q    <= shadow_dp_q;
                active_lz_q    <= shadow_lz_q;
                active_valid_q <= 1'b1;
            end
            if (i_load) begin
                shadow_value_q <= i_value;
                shadow_dp_q    <= i_dp;
                shadow_lz_q    <= i_lz_blank;
                pending_q      <= 1'b1;
            end else if (wrap && pending_q) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign o_digit_sel  = sel_q;
    assign o_seg        = seg_q;
    assign o_digit_idx  = idx_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomized self-checking bench for fnd_scan_driver against a cycle-indexed
// reference model built from frame arithmetic and a log of loads.
module tb_fnd_scan_driver;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 10;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic        i_clk      = 1'b0;
    logic        i_reset_n  = 1'b0;
    logic [15:0] i_value    = '0;
    logic [3:0]  i_dp       = '0;
    logic        i_lz_blank = 1'b0;
    logic        i_load     = 1'b0;
    logic [3:0]  o_digit_sel;
    logic [7:0]  o_seg;
    logic [1:0]  o_digit_idx;
    logic        o_frame_done;

    fnd_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_value      (i_value),
        .i_dp         (i_dp),
        .i_lz_blank   (i_lz_blank),
        .i_load       (i_load),
        .o_digit_sel  (o_digit_sel),
        .o_seg        (o_seg),
        .o_digit_idx  (o_digit_idx),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cyc;
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
    } load_t;

    load_t loads[$];
    load_t plan[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Outputs seen in cycle t describe the slot position of cycle t-1. Frame f
    // displays the newest load made at least two cycles before it starts.
    function automatic void expected_outputs(input int t, output logic [3:0] sel, output logic [7:0] seg);
        int    p, i, f;
        bit    valid;
        load_t cur;
        sel   = 4'hF;
        seg   = 8'hFF;
        valid = 1'b0;
        if (t == 0) return;
        p = (t - 1) % SCAN_DIV;
        i = ((t - 1) / SCAN_DIV) % DIGITS;
        f = (t - 1) / FRAME;
        if (p < BLANK_CYCLES) return;
        sel = ~(4'b0001 << i);
        foreach (loads[j]) begin
            if (loads[j].cyc <= f * FRAME - 2) begin
                cur   = loads[j];
                valid = 1'b1;
            end
        end
        if (!valid) return;
        if (cur.lz && i > 0 && (cur.value >> (4 * i)) == 16'h0) return;
        seg = hex_glyph(cur.value[4*i +: 4]);
        if (cur.dp[i]) seg[7] = 1'b0;
    endfunction

    task automatic check_cycle();
        logic [3:0] es;
        logic [7:0] eg;
        expected_outputs(cyc, es, eg);
        check("digit_sel", o_digit_sel, es);
        check("seg", o_seg, eg);
        check("digit_idx", o_digit_idx, (cyc / SCAN_DIV) % DIGITS);
        check("frame_done", o_frame_done, (cyc % FRAME) == FRAME - 1);
    endtask

    task automatic apply_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        load_t l;
        l.cyc = cyc; l.value = v; l.dp = dp; l.lz = lz;
        i_value = v; i_dp = dp; i_lz_blank = lz; i_load = 1'b1;
        loads.push_back(l);
    endtask

    // mode 0: no loads, 1: directed plan, 2: random loads
    task automatic run_cycles(input int n, input int mode);
        logic [15:0] masks [5];
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        for (int k = 0; k < n; k++) begin
            check_cycle();
            if (mode == 1) begin
                foreach (plan[j])
                    if (plan[j].cyc == cyc) apply_load(plan[j].value, plan[j].dp, plan[j].lz);
            end else if (mode == 2 && $urandom_range(7) == 0) begin
                apply_load(16'($urandom) & masks[$urandom_range(4)], 4'($urandom), 1'($urandom));
            end
            @(posedge i_clk);
            #1;
            cyc++;
            i_load = 1'b0;
        end
    endtask

    task automatic start_run();
        i_reset_n = 1'b0;
        i_load    = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_sel", o_digit_sel, 4'hF);
        check("reset_seg", o_seg, 8'hFF);
        check("reset_idx", o_digit_idx, 2'd0);
        check("reset_frame_done", o_frame_done, 1'b0);
        i_reset_n = 1'b1;
        cyc       = 0;
        loads.delete();
    endtask

    function automatic load_t mk(input int c, input logic [15:0] v, input logic [3:0] dp, input logic lz);
        load_t l;
        l.cyc = c; l.value = v; l.dp = dp; l.lz = lz;
        return l;
    endfunction

    initial begin
        plan.push_back(mk(10,  16'h1A0F, 4'b0100, 1'b0));
        plan.push_back(mk(39,  16'h2222, 4'b0000, 1'b0));
        plan.push_back(mk(90,  16'h0005, 4'b0000, 1'b1));
        plan.push_back(mk(130, 16'h0005, 4'b0000, 1'b0));
        plan.push_back(mk(199, 16'h0000, 4'b0001, 1'b1));

        start_run();
        run_cycles(280, 1);
        run_cycles(400, 2);

        while (cyc % FRAME != 25) run_cycles(1, 0);
        check_cycle();
        #2;
        i_reset_n = 1'b0;
        #1;
        check("async_sel", o_digit_sel, 4'hF);
        check("async_seg", o_seg, 8'hFF);
        check("async_idx", o_digit_idx, 2'd0);
        check("async_frame_done", o_frame_done, 1'b0);

        start_run();
        run_cycles(2 * FRAME + 10, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
